sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO; successor to the dual-clock FIFO used by the async FIFO BFM.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_dpram.sv | 26 ++
 rtl/sync_fifo_param.sv | 122 ++++++++++++
 tb/tb_sync_fifo_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock parametrised FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH_DEFAULT = 8;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_WIDTH_DEFAULT,
    parameter int DEPTH  = 16
)(
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost flags, optional FWFT read and sticky errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH      = 16,
    parameter int AFULL_THRESH    = 12,
    parameter int AEMPTY_THRESH   = 4,
    parameter int FWFT            = 0
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          winc,
    input  logic [FIFO_DATA_WIDTH-1:0]    wdata,
    output logic                          wfull,
    output logic                          walmost_full,
    input  logic                          rinc,
    output logic [FIFO_DATA_WIDTH-1:0]    rdata,
    output logic                          rempty,
    output logic                          ralmost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ptr_width(FIFO_DEPTH);
    localparam fifo_mode_e MODE = fifo_mode_e'(FWFT != 0);

    logic [PTR_W-1:0] wptr_reg, wptr_next;
    logic [PTR_W-1:0] rptr_reg, rptr_next;
    logic [PTR_W-1:0] count_reg, count_next;
    logic wfull_reg, wfull_next;
    logic walmost_full_reg, walmost_full_next;
    logic rempty_reg, rempty_next;
    logic ralmost_empty_reg, ralmost_empty_next;
    logic overflow_reg, overflow_next;
    logic underflow_reg, underflow_next;
    logic wr_ok, rd_ok;
    logic [FIFO_DATA_WIDTH-1:0] ram_q;

    // Accept decisions use only the flags registered before this edge.
    assign wr_ok = winc & ~wfull_reg;
    assign rd_ok = rinc & ~rempty_reg;

    always_comb begin
        wptr_next  = wptr_reg + PTR_W'(wr_ok);
        rptr_next  = rptr_reg + PTR_W'(rd_ok);
        count_next = count_reg + PTR_W'(wr_ok) - PTR_W'(rd_ok);
        wfull_next = (wptr_next[ADDR_W-1:0] == rptr_next[ADDR_W-1:0]) &&
                     (wptr_next[ADDR_W] != rptr_next[ADDR_W]);
        rempty_next        = (wptr_next == rptr_next);
        walmost_full_next  = (count_next >= PTR_W'(AFULL_THRESH));
        ralmost_empty_next = (count_next <= PTR_W'(AEMPTY_THRESH));
        // A new error in the same cycle as clr_err wins.
        overflow_next  = (winc & wfull_reg)  | (overflow_reg  & ~clr_err);
        underflow_next = (rinc & rempty_reg) | (underflow_reg & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg          <= '0;
            rptr_reg          <= '0;
            count_reg         <= '0;
            wfull_reg         <= 1'b0;
            walmost_full_reg  <= 1'b0;
            rempty_reg        <= 1'b1;
            ralmost_empty_reg <= 1'b1;
            overflow_reg      <= 1'b0;
            underflow_reg     <= 1'b0;
        end else begin
            wptr_reg          <= wptr_next;
            rptr_reg          <= rptr_next;
            count_reg         <= count_next;
            wfull_reg         <= wfull_next;
            walmost_full_reg  <= walmost_full_next;
            rempty_reg        <= rempty_next;
            ralmost_empty_reg <= ralmost_empty_next;
            overflow_reg      <= overflow_next;
            underflow_reg     <= underflow_next;
        end
    end

    fifo_dpram #(
        .DATA_W (FIFO_DATA_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wptr_reg[ADDR_W-1:0]),
        .wr_data (wdata),
        .rd_addr (rptr_reg[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    generate
        if (MODE == fifo_pkg::FWFT) begin : g_fwft
            // Head of queue falls through; forced to zero while empty so reset reads 0.
            assign rdata = rempty_reg ? '0 : ram_q;
        end else begin : g_std
            logic [FIFO_DATA_WIDTH-1:0] rdata_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (rd_ok) begin
                    rdata_reg <= ram_q;
                end
            end
            assign rdata = rdata_reg;
        end
    endgenerate

    assign wfull         = wfull_reg;
    assign walmost_full  = walmost_full_reg;
    assign rempty        = rempty_reg;
    assign ralmost_empty = ralmost_empty_reg;
    assign count         = count_reg;
    assign overflow      = overflow_reg;
    assign underflow     = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: table-driven fill/drain plus corner-case sequences.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_err;
    // standard-mode instance
    logic       winc, rinc;
    logic [7:0] wdata, rdata;
    logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [4:0] count;
    // FWFT instance
    logic       winc_f, rinc_f;
    logic [7:0] wdata_f, rdata_f;
    logic       wfull_f, walmost_full_f, rempty_f, ralmost_empty_f, overflow_f, underflow_f;
    logic [4:0] count_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FIFO_DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(4), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
        .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(.FIFO_DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(4), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .winc(winc_f), .wdata(wdata_f), .wfull(wfull_f),
        .walmost_full(walmost_full_f), .rinc(rinc_f), .rdata(rdata_f), .rempty(rempty_f),
        .ralmost_empty(ralmost_empty_f), .count(count_f), .overflow(overflow_f),
        .underflow(underflow_f), .clr_err(clr_err)
    );

    typedef struct {
        logic       winc;
        logic [7:0] wdata;
        logic       rinc;
        logic [4:0] cnt;
        logic       full;
        logic       afull;
        logic       empty;
        logic       aempty;
        logic       chk_rd;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs [32];
    logic [7:0] q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        winc = 1'b0; rinc = 1'b0; winc_f = 1'b0; rinc_f = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_reset_std(input string tag);
        check({tag, " count"},         32'(count), 0);
        check({tag, " wfull"},         32'(wfull), 0);
        check({tag, " walmost_full"},  32'(walmost_full), 0);
        check({tag, " rempty"},        32'(rempty), 1);
        check({tag, " ralmost_empty"}, 32'(ralmost_empty), 1);
        check({tag, " rdata"},         32'(rdata), 0);
        check({tag, " overflow"},      32'(overflow), 0);
        check({tag, " underflow"},     32'(underflow), 0);
    endtask

    task automatic push(input logic [7:0] d);
        winc = 1'b1; wdata = d; step(); winc = 1'b0;
    endtask

    initial begin
        idle();
        wdata = 8'h00; wdata_f = 8'h00; rst_n = 1'b0;
        step(); step();

        // Reset values on both instances
        check_reset_std("reset");
        check("reset fwft rempty", 32'(rempty_f), 1);
        check("reset fwft rdata",  32'(rdata_f), 0);
        check("reset fwft count",  32'(count_f), 0);
        rst_n = 1'b1;

        // Fill 16 then drain 16: expected flags from count = after-op occupancy
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{winc: 1'b1, wdata: 8'(i), rinc: 1'b0, cnt: 5'(i + 1),
                        full: (i + 1 == 16), afull: (i + 1 >= 12), empty: 1'b0,
                        aempty: (i + 1 <= 4), chk_rd: 1'b0, rd: 8'h00};
            vecs[16 + i] = '{winc: 1'b0, wdata: 8'h00, rinc: 1'b1, cnt: 5'(15 - i),
                             full: 1'b0, afull: (15 - i >= 12), empty: (i == 15),
                             aempty: (15 - i <= 4), chk_rd: 1'b1, rd: 8'(i)};
        end
        for (int i = 0; i < 32; i++) begin
            winc = vecs[i].winc; wdata = vecs[i].wdata; rinc = vecs[i].rinc;
            step();
            winc = 1'b0; rinc = 1'b0;
            check($sformatf("vec%0d count", i),  32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d wfull", i),  32'(wfull), 32'(vecs[i].full));
            check($sformatf("vec%0d afull", i),  32'(walmost_full), 32'(vecs[i].afull));
            check($sformatf("vec%0d rempty", i), 32'(rempty), 32'(vecs[i].empty));
            check($sformatf("vec%0d aempty", i), 32'(ralmost_empty), 32'(vecs[i].aempty));
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].rd));
        end

        // Overflow: write while full is dropped and flag is sticky until clr_err
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        winc = 1'b1; wdata = 8'hEE; step(); winc = 1'b0;
        check("ovf count", 32'(count), 16);
        check("ovf flag", 32'(overflow), 1);
        step();
        check("ovf sticky", 32'(overflow), 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("ovf cleared", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            rinc = 1'b1; step(); rinc = 1'b0;
            check($sformatf("ovf drain %0d", i), 32'(rdata), 32'(8'h40 + 8'(i)));
        end

        // Underflow: read on empty, then simultaneous read/write on empty
        rinc = 1'b1; step(); rinc = 1'b0;
        check("udf flag", 32'(underflow), 1);
        check("udf rdata held", 32'(rdata), 32'h4F);
        check("udf count", 32'(count), 0);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("udf cleared", 32'(underflow), 0);
        winc = 1'b1; rinc = 1'b1; wdata = 8'h77; step(); winc = 1'b0; rinc = 1'b0;
        check("rw-empty count", 32'(count), 1);
        check("rw-empty underflow", 32'(underflow), 1);
        check("rw-empty rempty", 32'(rempty), 0);
        rinc = 1'b1; step(); rinc = 1'b0;
        check("rw-empty pop", 32'(rdata), 32'h77);
        clr_err = 1'b1; step(); clr_err = 1'b0;

        // Steady-state streaming at count=8 across pointer wrap
        q.delete();
        for (int i = 0; i < 8; i++) begin
            push(8'h80 + 8'(i));
            q.push_back(8'h80 + 8'(i));
        end
        for (int k = 0; k < 20; k++) begin
            logic [7:0] exp_d;
            winc = 1'b1; rinc = 1'b1; wdata = 8'hA0 + 8'(k);
            step();
            winc = 1'b0; rinc = 1'b0;
            exp_d = q.pop_front();
            q.push_back(8'hA0 + 8'(k));
            check($sformatf("stream%0d count", k), 32'(count), 8);
            check($sformatf("stream%0d rdata", k), 32'(rdata), 32'(exp_d));
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_d;
            rinc = 1'b1; step(); rinc = 1'b0;
            exp_d = q.pop_front();
            check($sformatf("stream drain %0d", i), 32'(rdata), 32'(exp_d));
        end
        check("stream empty", 32'(rempty), 1);

        // FWFT: head visible without rinc, pop empties
        winc_f = 1'b1; wdata_f = 8'hA5; step(); winc_f = 1'b0;
        check("fwft rempty", 32'(rempty_f), 0);
        check("fwft rdata", 32'(rdata_f), 32'hA5);
        step();
        check("fwft rdata hold", 32'(rdata_f), 32'hA5);
        rinc_f = 1'b1; step(); rinc_f = 1'b0;
        check("fwft pop empty", 32'(rempty_f), 1);
        check("fwft pop count", 32'(count_f), 0);
        winc_f = 1'b1; wdata_f = 8'h11; step();
        wdata_f = 8'h22; step(); winc_f = 1'b0;
        check("fwft head1", 32'(rdata_f), 32'h11);
        rinc_f = 1'b1; step(); rinc_f = 1'b0;
        check("fwft head2", 32'(rdata_f), 32'h22);
        check("fwft count1", 32'(count_f), 1);

        // Mid-operation reset discards contents
        for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
        check("prefill count", 32'(count), 10);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_reset_std("midrst");
        check("midrst fwft rempty", 32'(rempty_f), 1);
        push(8'h3C);
        check("post-rst count", 32'(count), 1);
        rinc = 1'b1; step(); rinc = 1'b0;
        check("post-rst rdata", 32'(rdata), 32'h3C);
        check("post-rst rempty", 32'(rempty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
